// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the MEM stage and a host port.
// The core has priority; a starvation counter forces a one-cycle core stall for the host.
module dmem_arbiter #(
    parameter int ADDR_W     = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_read,
    input  logic              core_write,
    input  logic [31:0]       core_addr,
    input  logic [31:0]       core_wdata,
    output logic [31:0]       core_rdata,
    output logic              core_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [31:0]       host_addr,
    input  logic [31:0]       host_wdata,
    output logic              host_gnt,
    output logic              host_ack,
    output logic [31:0]       host_rdata,
    output logic              host_err,
    output logic              misalign_err,
    output logic [15:0]       stall_count,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);
    localparam logic [3:0] SMAX = 4'(STARVE_MAX);
    logic [3:0] starve_cnt;
    logic core_act, frc, host_ok;
    assign core_act = core_read | core_write;
    assign frc = starve_cnt == SMAX;
    assign host_ok = host_addr[1:0] == 2'b00;
    assign host_gnt = reset & host_req & (!core_act | frc);
    assign core_stall = host_gnt & core_act;
    // a misaligned host grant still owns the port but issues no strobe
    assign mem_read = reset & (host_gnt ? host_ok & !host_we : core_read);
    assign mem_write = reset & (host_gnt ? host_ok & host_we : core_write);
    assign mem_addr = host_gnt ? host_addr[ADDR_W+1:2] : core_addr[ADDR_W+1:2];
    assign mem_wdata = host_gnt ? host_wdata : core_wdata;
    assign core_rdata = mem_rdata;
    // a denial implies !frc, so the increment can never pass STARVE_MAX
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            starve_cnt   <= 4'd0;
            host_ack     <= 1'b0;
            host_err     <= 1'b0;
            host_rdata   <= 32'd0;
            misalign_err <= 1'b0;
            stall_count  <= 16'd0;
        end else begin
            starve_cnt   <= host_gnt ? 4'd0 : (host_req & core_act) ? starve_cnt + 4'd1 : starve_cnt;
            host_ack     <= host_gnt;
            host_err     <= host_gnt & !host_ok;
            host_rdata   <= (host_gnt & host_ok & !host_we) ? mem_rdata : 32'd0;
            misalign_err <= misalign_err | (core_act & !core_stall & (core_addr[1:0] != 2'b00));
            if (core_stall && stall_count != 16'hFFFF)
                stall_count <= stall_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: table-driven arbitration vectors plus hand-written multi-cycle sequences.
module tb_dmem_arbiter;
    logic clk = 1'b0, reset = 1'b0;
    logic core_read = 1'b0, core_write = 1'b0, host_req = 1'b0, host_we = 1'b0;
    logic [31:0] core_addr = 32'd0, core_wdata = 32'd0, host_addr = 32'd0, host_wdata = 32'd0;
    logic [31:0] core_rdata, host_rdata, mem_wdata, mem_rdata;
    logic core_stall, host_gnt, host_ack, host_err, misalign_err, mem_read, mem_write;
    logic [15:0] stall_count;
    logic [9:0] mem_addr;
    logic [31:0] mem [0:1023];
    int checks = 0, errors = 0;

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_write) mem[mem_addr] <= mem_wdata;

    dmem_arbiter dut (
        .clk(clk), .reset(reset),
        .core_read(core_read), .core_write(core_write), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
        .host_gnt(host_gnt), .host_ack(host_ack), .host_rdata(host_rdata), .host_err(host_err),
        .misalign_err(misalign_err), .stall_count(stall_count),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    typedef struct {
        string       name;
        logic        cr, cw;
        logic [31:0] ca, cd;
        logic        hr, hw;
        logic [31:0] ha, hd;
        logic        gnt, stall, rd, wr;
        logic [9:0]  addr;
        logic [31:0] wd;
        logic        err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic hr, input logic hw, input logic [31:0] ha, input logic [31:0] hd);
        core_read = cr; core_write = cw; core_addr = ca; core_wdata = cd;
        host_req = hr; host_we = hw; host_addr = ha; host_wdata = hd;
    endtask

    initial begin
        vec_t v [8];
        v[0] = '{"idle",     0,0,32'h40,32'h11, 0,0,32'h10,32'h22, 0,0,0,0, 10'd16, 32'h11, 0};
        v[1] = '{"core_rd",  1,0,32'h40,32'h11, 0,0,32'h10,32'h22, 0,0,1,0, 10'd16, 32'h11, 0};
        v[2] = '{"core_wr",  0,1,32'h44,32'h11, 0,0,32'h10,32'h22, 0,0,0,1, 10'd17, 32'h11, 0};
        v[3] = '{"host_rd",  0,0,32'h40,32'h11, 1,0,32'h10,32'h22, 1,0,1,0, 10'd4,  32'h22, 0};
        v[4] = '{"host_wr",  0,0,32'h40,32'h11, 1,1,32'h24,32'h22, 1,0,0,1, 10'd9,  32'h22, 0};
        v[5] = '{"host_mis", 0,0,32'h40,32'h11, 1,0,32'h22,32'h22, 1,0,0,0, 10'd8,  32'h22, 1};
        v[6] = '{"both_rd",  1,0,32'h40,32'h11, 1,0,32'h10,32'h22, 0,0,1,0, 10'd16, 32'h11, 0};
        v[7] = '{"both_wr",  0,1,32'h48,32'h11, 1,1,32'h30,32'h22, 0,0,0,1, 10'd18, 32'h11, 0};

        // reset held with every request active
        drive(1, 1, 32'h40, 32'h1, 1, 1, 32'h10, 32'h2);
        step();
        chk("rst_gnt", host_gnt, 0);
        chk("rst_stall", core_stall, 0);
        chk("rst_mem_read", mem_read, 0);
        chk("rst_mem_write", mem_write, 0);
        step();
        chk("rst_ack", host_ack, 0);
        chk("rst_rdata", host_rdata, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk("rel_stall_count", stall_count, 0);
        chk("rel_misalign", misalign_err, 0);

        for (int i = 0; i < 8; i++) begin
            drive(v[i].cr, v[i].cw, v[i].ca, v[i].cd, v[i].hr, v[i].hw, v[i].ha, v[i].hd);
            #1;
            chk({v[i].name, "_gnt"}, host_gnt, v[i].gnt);
            chk({v[i].name, "_stall"}, core_stall, v[i].stall);
            chk({v[i].name, "_rd"}, mem_read, v[i].rd);
            chk({v[i].name, "_wr"}, mem_write, v[i].wr);
            chk({v[i].name, "_addr"}, mem_addr, v[i].addr);
            chk({v[i].name, "_wdata"}, mem_wdata, v[i].wd);
            step();
            chk({v[i].name, "_ack"}, host_ack, v[i].gnt);
            chk({v[i].name, "_err"}, host_err, v[i].err);
            // misaligned host grant with idle core clears the starvation counter, touches no memory
            drive(0, 0, 0, 0, 1, 0, 32'h3, 0);
            step();
            drive(0, 0, 0, 0, 0, 0, 0, 0);
        end

        // host-only read of a preloaded word
        drive(0, 0, 0, 0, 1, 1, 32'h10, 32'hDEADBEEF);
        step();
        drive(0, 0, 0, 0, 1, 0, 32'h10, 0);
        #1;
        chk("hrd_gnt", host_gnt, 1);
        chk("hrd_addr", mem_addr, 4);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("hrd_ack", host_ack, 1);
        chk("hrd_rdata", host_rdata, 32'hDEADBEEF);
        chk("hrd_err", host_err, 0);
        step();
        chk("hrd_ack_one_cycle", host_ack, 0);

        // starvation: four denials, one forced grant, then core again
        drive(1, 0, 32'h40, 0, 1, 0, 32'h10, 0);
        for (int c = 1; c <= 4; c++) begin
            #1;
            chk($sformatf("starve_c%0d_gnt", c), host_gnt, 0);
            chk($sformatf("starve_c%0d_rd", c), mem_read, 1);
            step();
        end
        chk("starve_c5_gnt", host_gnt, 1);
        chk("starve_c5_stall", core_stall, 1);
        chk("starve_c5_addr", mem_addr, 4);
        step();
        chk("starve_stall_count", stall_count, 1);
        chk("starve_ack", host_ack, 1);
        chk("starve_rdata", host_rdata, 32'hDEADBEEF);
        chk("starve_c6_gnt", host_gnt, 0);
        chk("starve_c6_stall", core_stall, 0);
        chk("starve_c6_addr", mem_addr, 16);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        step();

        // handoff: host write then core read of the same word
        drive(0, 0, 0, 0, 1, 1, 32'h20, 32'h55);
        step();
        drive(1, 0, 32'h20, 0, 0, 0, 0, 0);
        #1;
        chk("handoff_rdata", core_rdata, 32'h55);
        chk("handoff_ack", host_ack, 1);
        step();

        // misaligned host write
        drive(0, 0, 0, 0, 1, 1, 32'h22, 32'hAA);
        #1;
        chk("hmis_gnt", host_gnt, 1);
        chk("hmis_write", mem_write, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("hmis_ack", host_ack, 1);
        chk("hmis_err", host_err, 1);
        chk("hmis_rdata", host_rdata, 0);
        chk("hmis_mem_kept", mem[8], 32'h55);

        // misaligned core read is sticky
        chk("cmis_before", misalign_err, 0);
        drive(1, 0, 32'h13, 0, 0, 0, 0, 0);
        #1;
        chk("cmis_addr", mem_addr, 4);
        chk("cmis_rd", mem_read, 1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("cmis_set", misalign_err, 1);
        step();
        step();
        chk("cmis_sticky", misalign_err, 1);

        // reset asserted in the grant cycle of a host read
        drive(0, 0, 0, 0, 1, 0, 32'h10, 0);
        #1;
        chk("mid_gnt", host_gnt, 1);
        reset = 1'b0;
        #1;
        chk("mid_gnt_forced", host_gnt, 0);
        chk("mid_rd_forced", mem_read, 0);
        step();
        chk("mid_ack_dropped", host_ack, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
        #1;
        chk("mid_stall_count", stall_count, 0);
        chk("mid_misalign", misalign_err, 0);
        step();
        chk("mid_ack_after", host_ack, 0);
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0);
        #1;
        chk("mid_mem_kept", core_rdata, 32'hDEADBEEF);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Shares the single-port data memory between the pipeline MEM stage and a host/debug port. Used for program/data loading, inspection and test injection. Sits between the EX/MEM pipeline register outputs and the `data_memory` instance. The core has priority. A starvation counter guarantees host progress by forcing a one-cycle core stall, which drives the pipeline register write enables and the PC write enable.

## Interface
Parameters:
- `ADDR_W`, default 10: word-address width driven to memory.
- `STARVE_MAX`, default 4, legal range 1..15: consecutive host denials before a forced host grant.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `core_read`, `core_write`, input, 1 each: MEM-stage access request (MemRead/MemWrite).
- `core_addr`, input, 32: byte address (ALU result).
- `core_wdata`, input, 32: store data.
- `core_rdata`, output, 32: load data, combinational from `mem_rdata`.
- `core_stall`, output, 1: freeze all pipeline registers and PC this cycle.
- `host_req`, input, 1: host access request; held until `host_gnt`.
- `host_we`, input, 1: 1 = write, 0 = read.
- `host_addr`, input, 32: byte address.
- `host_wdata`, input, 32: write data.
- `host_gnt`, output, 1: host owns memory this cycle (combinational).
- `host_ack`, output, 1: registered one-cycle response pulse, one cycle after each grant.
- `host_rdata`, output, 32: registered read data, valid with `host_ack`.
- `host_err`, output, 1: registered; accompanies `host_ack` when the granted access was misaligned.
- `misalign_err`, output, 1: sticky flag for a misaligned core access.
- `stall_count`, output, 16: saturating count of `core_stall` cycles.
- `mem_read`, `mem_write`, output, 1 each: memory strobes.
- `mem_addr`, output, `ADDR_W`: word address, equal to byte address bits [`ADDR_W`+1:2].
- `mem_wdata`, output, 32: memory write data.
- `mem_rdata`, input, 32: memory read data; asynchronous read, write on `clk` rise.

## Operation
- Definitions: `core_act` = `core_read` | `core_write`; `force` = (`starve_cnt` == `STARVE_MAX`).
- Arbitration is combinational, every cycle:
  - Host granted if `host_req` & (!`core_act` | `force`).
  - `core_stall` = `host_gnt` & `core_act`.
  - Otherwise the core drives the memory port: `mem_read` = `core_read`, `mem_write` = `core_write`.
  - No requester: `mem_read` = `mem_write` = 0; `mem_addr` and `mem_wdata` driven from the core inputs.
- `starve_cnt` (4-bit register):
  - Cleared to 0 on any host grant.
  - Incremented when `host_req` & `core_act` & !`host_gnt`.
  - Otherwise held.
  - Never exceeds `STARVE_MAX`.
- A stalled core holds its request. The cycle after a forced grant, `starve_cnt` = 0, so the core wins. Back-to-back core stalls are therefore impossible while the core keeps requesting.
- Host access:
  - Aligned (`host_addr[1:0]` == 0): memory driven from the host signals.
  - Misaligned: granted, but `mem_read` = `mem_write` = 0. Next cycle `host_ack` = 1, `host_err` = 1, `host_rdata` = 0.
  - Aligned read: `host_rdata` captures `mem_rdata` at the grant edge.
  - Aligned write: `host_rdata` = 0, `host_err` = 0.
- Core misaligned access (`core_addr[1:0]` != 0 while `core_act` and not stalled):
  - The access proceeds at the truncated word address.
  - `misalign_err` is set on the next edge and is cleared only by reset.
- `stall_count` increments on each edge where `core_stall` = 1 and saturates at 0xFFFF.
- While `reset` = 0:
  - Combinational outputs are forced: `host_gnt`, `core_stall`, `mem_read`, `mem_write` = 0.
  - All registers are cleared: `starve_cnt`, `host_ack`, `host_err`, `host_rdata`, `misalign_err`, `stall_count` = 0.

## Timing
- Reset value of every registered output is 0. Deassertion is synchronized externally; the first arbitration happens in the first cycle after release.
- Grant latency:
  - Core: 0 cycles.
  - Host with idle core: 0 cycles.
  - Host with a continuously busy core: exactly `STARVE_MAX` denied cycles, then granted.
- Host response: `host_ack` follows `host_gnt` by exactly 1 cycle and lasts 1 cycle. A new request may be granted in the same cycle as the previous `host_ack`.
- Write-then-read:
  - A host write in cycle N is visible to a core read in cycle N+1.
  - Same-address writes never collide, since only one owner per cycle.
- Reset asserted mid-grant: the pending `host_ack` is dropped. A write committed on the edge before reset remains in memory.

## Test plan
- Reset: hold `reset` = 0 with all requests high, then release. All outputs are 0 during reset; `stall_count` = 0 and `misalign_err` = 0 after release.
- Host-only read: preload word 4 = 0xDEADBEEF, core idle, `host_req` = 1, `host_we` = 0, `host_addr` = 0x10. Expect `host_gnt` = 1 and `mem_addr` = 4 in the same cycle; next cycle `host_ack` = 1 and `host_rdata` = 0xDEADBEEF.
- Starvation (`STARVE_MAX` = 4): `core_read` held high, `host_req` held high. Expect cycles 1-4 core-owned with `host_gnt` = 0; cycle 5 `host_gnt` = 1, `core_stall` = 1; `stall_count` = 1; cycle 6 core-owned again.
- Handoff: host writes 0x55 to 0x20 while core idle; core reads 0x20 next cycle. Expect `core_rdata` = 0x00000055.
- Misalignment:
  - Host write to 0x22: `host_ack` = 1, `host_err` = 1, `mem_write` never 1.
  - Core read at 0x13: `mem_addr` = 4 and `misalign_err` = 1, sticky until reset.
- Reset mid-grant: drop `reset` in the grant cycle of a host read. `host_ack` is never asserted; `starve_cnt` and `stall_count` = 0 after release.
